wb_retire: RTL
==============

Name: wb_retire

Overview:
- Write-back/retire stage: the write side of the architectural register file that operand fetch reads.
- Accepts results from execute through a valid/ready handshake and buffers them in an in-order queue.
- Register-destination results are merged into the 16x64 file with x86 partial-width rules. Memory-destination results go out on a store request/acknowledge port.
- Drives the regx[16] array read by operand fetch. Drives a per-register pending mask that operand fetch uses to stall on RAW hazards.

Parameters:
DEPTH, 4, result queue entries; power of two, >= 2
RSP_INIT, 64'h0, reset value of regx[4] (RSP); all other registers reset to 0

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
wb_valid  in  1  execute presents a result
wb_ready  out  1  queue can accept; = !full
wb_nop  in  1  bubble; accepted but not queued
wb_dstty  in  2  0=REGISTER, 1=MEMORY; other values treated as nop
wb_dstreg  in  4  destination register index (RAX=0..R15=15)
wb_size  in  2  00=8b, 01=16b, 10=32b, 11=64b
wb_result  in  64  result value
wb_addr  in  64  store address (MEMORY only)
regx  out  16x64  architectural registers, registered outputs
pending  out  16  bit r=1 while any queued REGISTER entry targets r
st_req  out  1  store request
st_addr  out  64  store address
st_data  out  64  store data, masked to size, upper bits zero
st_size  out  2  store size code
st_ack  in  1  store accepted, single-cycle pulse
busy  out  1  queue non-empty or store in flight

Behaviour:
- Reset (reset==0 at a clk edge):
  - regx all 0 except regx[4]=RSP_INIT.
  - Queue empty, FSM=IDLE, st_req=0, st_addr/st_data/st_size=0, pending=0, busy=0.
  - wb_ready=1 in the first cycle after reset deasserts.
  - A store in flight is abandoned: st_req low next cycle, entry discarded, no regx change.
- Enqueue:
  - Occurs when wb_valid && wb_ready at an edge.
  - wb_nop=1 or invalid dstty: entry dropped, no state change.
  - wb_ready=0 when DEPTH entries are held, even if the head retires that same cycle. No bypass of a full queue.
- Retire is strictly in order, at most one entry per cycle, from the queue head. FSM states IDLE and STORE.
  - IDLE, head is REGISTER: write at the next edge and pop.
    - size 00: regx[r][7:0] = res[7:0]; bits 63:8 unchanged.
    - size 01: regx[r][15:0] = res[15:0]; bits 63:16 unchanged.
    - size 10: regx[r] = {32'h0, res[31:0]}.
    - size 11: regx[r] = res.
  - IDLE, head is MEMORY: go to STORE.
    - st_req=1; st_addr, st_data and st_size load from the head.
    - st_data is the result masked to 8/16/32/64 bits, upper bits zero.
  - STORE: st_req and the store outputs are held stable until st_ack=1.
    - On the st_ack edge: pop, st_req=0 next cycle, return to IDLE.
    - Entries behind the store, including REGISTER entries, wait.
  - st_ack while st_req=0 is ignored.
- Latency: an entry enqueued at edge N into an empty, idle queue updates regx at edge N+1. A store entry asserts st_req after edge N+1.
- Simultaneous enqueue and retire in the same cycle: both happen; the count is unchanged. Pointers wrap modulo DEPTH.
- pending:
  - Combinational OR over valid queued REGISTER entries. It includes an entry being written this cycle, and clears the cycle after its write.
  - MEMORY entries never set pending.
- busy = queue non-empty || FSM==STORE.
- Same register targeted by consecutive entries: writes apply in order; the final value equals sequential x86 semantics.

Test Plan:
- Reset: hold reset=0 two cycles -> regx[0..15]=0 with regx[4]=RSP_INIT, wb_ready=1, pending=0, st_req=0, busy=0.
- Partial-width merge:
  - Write RAX size11 0x1122334455667788, then size00 0xAB -> RAX=0x11223344556677AB.
  - Then size01 0xCDEF -> 0x112233445566CDEF.
  - Then size10 0x9 -> 0x0000000000000009.
- Store handshake: MEMORY addr 0x1000, size 10, result 0xFFFFFFFF_12345678 -> st_req=1, st_data=0x12345678, st_size=10.
  - Hold st_ack=0 for 5 cycles -> outputs stable.
  - A following REGISTER write to RBX stays pending with bit3=1 until the cycle after st_ack.
- Full queue: with st_ack held low, push DEPTH entries -> wb_ready=0; a 5th offered entry is not accepted.
  - Pulse st_ack -> wb_ready=1 next cycle, remaining entries drain one per cycle, and regx matches push order.
- Nop/back-to-back: alternate wb_nop=1 and REGISTER writes to R15 (1,2,3) every cycle -> R15=3, and the nops never occupy the queue.
- Reset mid-store: st_req=1, drive reset=0 one cycle -> st_req=0, queue empty, regx unchanged from reset values, and a late st_ack is ignored.

Source files
------------

// File: rtl/wb_retire_if.sv
// wb_retire_if: groups the execute->retire result handshake and the
// store request/acknowledge port of the write-back stage.
//   wb_valid/wb_ready       result handshake (ready = queue not full)
//   wb_nop, wb_dstty        bubble flag, destination type (0=REG, 1=MEM)
//   wb_dstreg, wb_size      destination register index, size code
//   wb_result, wb_addr      result value, store address
//   st_req/st_ack           store request, single-cycle acknowledge
//   st_addr/st_data/st_size store payload, held while st_req is high
interface wb_retire_if;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_nop;
    logic [1:0]  wb_dstty;
    logic [3:0]  wb_dstreg;
    logic [1:0]  wb_size;
    logic [63:0] wb_result;
    logic [63:0] wb_addr;

    logic        st_req;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic [1:0]  st_size;
    logic        st_ack;

    modport slave (
        input  wb_valid, wb_nop, wb_dstty, wb_dstreg, wb_size, wb_result, wb_addr,
        input  st_ack,
        output wb_ready,
        output st_req, st_addr, st_data, st_size
    );

    modport master (
        output wb_valid, wb_nop, wb_dstty, wb_dstreg, wb_size, wb_result, wb_addr,
        output st_ack,
        input  wb_ready,
        input  st_req, st_addr, st_data, st_size
    );
endinterface

// File: rtl/wb_retire.sv
// wb_retire: write-back/retire stage. Buffers execute results in an in-order
// queue and retires at most one per cycle: register results are merged into
// the 16x64 architectural file with x86 partial-width rules, memory results
// are issued on the store request/acknowledge port.
// Ports:
//   clk, reset  clock, synchronous active-low reset
//   bus         wb_retire_if.slave (result handshake + store port)
//   regx        registered architectural register file, read by operand fetch
//   pending     bit r set while any queued register entry targets r
//   busy        queue non-empty or store in flight
module wb_retire #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RSP_INIT = 64'h0
) (
    input  logic              clk,
    input  logic              reset,
    wb_retire_if.slave        bus,
    output logic [63:0]       regx [16],
    output logic [15:0]       pending,
    output logic              busy
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef enum logic {S_IDLE, S_STORE} state_t;

    typedef struct packed {
        logic        mem;
        logic [3:0]  dreg;
        logic [1:0]  size;
        logic [63:0] res;
        logic [63:0] addr;
    } entry_t;

    state_t      state_q, state_d;
    entry_t      q_q [DEPTH];
    entry_t      q_d [DEPTH];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic [63:0] regx_q [16];
    logic [63:0] regx_d [16];
    logic [63:0] st_addr_q, st_addr_d, st_data_q, st_data_d;
    logic [1:0]  st_size_q, st_size_d;

    logic        push, pop;
    entry_t      head_e;
    logic [PW-1:0] pend_off;

    function automatic logic [63:0] size_mask(input logic [1:0] sz);
        case (sz)
            2'b00:   size_mask = 64'h0000_0000_0000_00FF;
            2'b01:   size_mask = 64'h0000_0000_0000_FFFF;
            2'b10:   size_mask = 64'h0000_0000_FFFF_FFFF;
            default: size_mask = '1;
        endcase
    endfunction

    // 8/16-bit writes keep the upper bits; 32-bit writes zero-extend.
    function automatic logic [63:0] merge(input logic [63:0] old,
                                          input logic [63:0] res,
                                          input logic [1:0]  sz);
        logic [63:0] m;
        m = size_mask(sz);
        if (sz[1]) merge = res & m;
        else       merge = (old & ~m) | (res & m);
    endfunction

    assign bus.wb_ready = (count_q != FULL_CNT);
    assign bus.st_req   = (state_q == S_STORE);
    assign bus.st_addr  = st_addr_q;
    assign bus.st_data  = st_data_q;
    assign bus.st_size  = st_size_q;
    assign busy         = (count_q != '0) || (state_q == S_STORE);
    assign regx         = regx_q;

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        head_d    = head_q;
        tail_d    = tail_q;
        regx_d    = regx_q;
        st_addr_d = st_addr_q;
        st_data_d = st_data_q;
        st_size_d = st_size_q;
        pop       = 1'b0;
        head_e    = q_q[head_q];

        push = bus.wb_valid && bus.wb_ready && !bus.wb_nop && !bus.wb_dstty[1];

        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    if (!head_e.mem) begin
                        regx_d[head_e.dreg] = merge(regx_q[head_e.dreg], head_e.res, head_e.size);
                        pop = 1'b1;
                    end else begin
                        st_addr_d = head_e.addr;
                        st_data_d = head_e.res & size_mask(head_e.size);
                        st_size_d = head_e.size;
                        state_d   = S_STORE;
                    end
                end
            end
            S_STORE: begin
                // Store entry stays at the head until acknowledged.
                if (bus.st_ack) begin
                    pop     = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (push) begin
            q_d[tail_q] = '{mem:  bus.wb_dstty[0],
                            dreg: bus.wb_dstreg,
                            size: bus.wb_size,
                            res:  bus.wb_result,
                            addr: bus.wb_addr};
            tail_d = tail_q + 1'b1;
        end
        if (pop) head_d = head_q + 1'b1;

        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    // Slot i is live when its distance from the head is below the count.
    always_comb begin
        pending  = '0;
        pend_off = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            pend_off = PW'(i) - head_q;
            if (({1'b0, pend_off} < count_q) && !q_q[i].mem)
                pending[q_q[i].dreg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            st_addr_q <= '0;
            st_data_q <= '0;
            st_size_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) q_q[i] <= '0;
            for (int unsigned i = 0; i < 16; i++)
                regx_q[i] <= (i == 4) ? RSP_INIT : '0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            st_addr_q <= st_addr_d;
            st_data_q <= st_data_d;
            st_size_q <= st_size_d;
            q_q       <= q_d;
            regx_q    <= regx_d;
        end
    end
endmodule
